// File: rtl/usbf_arb_pkg.sv
// Shared types and constants for the USB function DMA arbitration logic.
package usbf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int USBF_MAX_EP = 16;
    localparam int USBF_SEL_W  = 4;

endpackage

// File: rtl/usbf_rr_pick.sv
// Combinational round-robin picker: first eligible index above `last`, wrapping.
module usbf_rr_pick
    import usbf_arb_pkg::*;
#(
    parameter int NUM_EP = 4
) (
    input  logic [NUM_EP-1:0]     eligible,
    input  logic [USBF_SEL_W-1:0] last,
    output logic [USBF_SEL_W-1:0] pick,
    output logic                  any
);

    logic [USBF_MAX_EP-1:0] elig_pad;

    assign elig_pad = USBF_MAX_EP'(eligible);

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        for (int off = NUM_EP; off >= 1; off--) begin
            if (elig_pad[USBF_SEL_W'((int'(last) + off) % NUM_EP)]) begin
                pick = USBF_SEL_W'((int'(last) + off) % NUM_EP);
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usbf_ep_dma_arb.sv
// Round-robin arbiter sharing the external DMA channel among endpoint register files.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | no grant; pick next eligible endpoint after `last`
//   GRANT   | dma_req high, dma_ack steered to ep_dma_ack[dma_sel]
//   RELEASE | one dead cycle so the endpoint's post-ack request drop is seen
module usbf_ep_dma_arb
    import usbf_arb_pkg::*;
#(
    parameter int NUM_EP    = 4,
    parameter int BURST_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_EP-1:0]     ep_dma_req,
    input  logic [NUM_EP-1:0]     ep_dma_en,
    output logic [NUM_EP-1:0]     ep_dma_ack,
    output logic                  dma_req,
    output logic [USBF_SEL_W-1:0] dma_sel,
    input  logic                  dma_ack,
    output logic                  arb_err
);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [USBF_SEL_W-1:0]  last;
    logic [7:0]             burst_cnt;
    logic [USBF_SEL_W-1:0]  pick;
    logic                   pick_any;
    logic [USBF_MAX_EP-1:0] req_pad;
    logic [USBF_MAX_EP-1:0] en_pad;
    logic [USBF_MAX_EP-1:0] ack_pad;
    logic                   burst_end;
    logic                   grant_exit;

    usbf_rr_pick #(
        .NUM_EP (NUM_EP)
    ) u_pick (
        .eligible (ep_dma_req & ep_dma_en),
        .last     (last),
        .pick     (pick),
        .any      (pick_any)
    );

    assign req_pad = USBF_MAX_EP'(ep_dma_req);
    assign en_pad  = USBF_MAX_EP'(ep_dma_en);

    // An ack coinciding with a request drop keeps the grant; the drop is judged next cycle.
    assign burst_end  = dma_ack && (({1'b0, burst_cnt} + 9'd1) == 9'(BURST_MAX));
    assign grant_exit = burst_end
                      || (!req_pad[dma_sel] && !dma_ack)
                      || !en_pad[dma_sel];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_any)   state_nxt = GRANT;
            GRANT:   if (grant_exit) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant bookkeeping, saturating burst counter and stray-ack flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dma_sel   <= '0;
            last      <= USBF_SEL_W'(NUM_EP - 1);
            burst_cnt <= '0;
            arb_err   <= 1'b0;
        end else begin
            arb_err <= dma_ack && (state != GRANT);
            if (state == IDLE && pick_any) begin
                dma_sel   <= pick;
                last      <= pick;
                burst_cnt <= '0;
            end else if (state == GRANT && dma_ack && burst_cnt != 8'(BURST_MAX)) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
        end
    end

    assign dma_req = (state == GRANT);

    // Acks in the reset cycle are suppressed so no endpoint sees a transfer that reset discards.
    assign ack_pad    = (state == GRANT && rst) ? (USBF_MAX_EP'(dma_ack) << dma_sel) : '0;
    assign ep_dma_ack = ack_pad[NUM_EP-1:0];

endmodule

// File: tb/tb_usbf_ep_dma_arb.sv
// Self-checking bench for usbf_ep_dma_arb: directed scenarios plus randomized traffic
// compared every cycle against a behavioural arbitration model.
module tb_usbf_ep_dma_arb;

    localparam int N = 4;
    localparam int B = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] en  = '0;
    logic         dack = 1'b0;
    logic [N-1:0] ack_o;
    logic         dreq;
    logic [3:0]   dsel;
    logic         err;

    int vec = 0;
    int mis = 0;

    always #5 clk = ~clk;

    usbf_ep_dma_arb #(
        .NUM_EP    (N),
        .BURST_MAX (B)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ep_dma_req (req),
        .ep_dma_en  (en),
        .ep_dma_ack (ack_o),
        .dma_req    (dreq),
        .dma_sel    (dsel),
        .dma_ack    (dack),
        .arb_err    (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a grant is either active, in its one-cycle cool-down, or absent.
    bit m_busy, m_gap, m_err;
    int m_sel, m_last, m_cnt;

    task automatic model_step();
        bit done, found;
        int c;
        if (!rst) begin
            m_busy = 0; m_gap = 0; m_err = 0;
            m_sel = 0; m_last = N - 1; m_cnt = 0;
        end else begin
            m_err = dack && !m_busy;
            if (m_busy) begin
                done = (dack && (m_cnt + 1 == B)) || (!req[m_sel] && !dack) || !en[m_sel];
                if (dack) m_cnt = (m_cnt + 1 > B) ? B : m_cnt + 1;
                if (done) begin
                    m_busy = 0;
                    m_gap  = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && req[c] && en[c]) begin
                        found  = 1;
                        m_sel  = c;
                        m_last = c;
                        m_cnt  = 0;
                        m_busy = 1;
                    end
                end
            end
        end
    endtask

    // Compare process: update model on each edge, check outputs mid-cycle.
    initial begin
        int exp_ack;
        m_busy = 0; m_gap = 0; m_err = 0; m_sel = 0; m_last = N - 1; m_cnt = 0;
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            exp_ack = (m_busy && rst && dack) ? (1 << m_sel) : 0;
            chk("dma_req",    32'(dreq),  32'(m_busy));
            chk("dma_sel",    32'(dsel),  m_sel);
            chk("ep_dma_ack", 32'(ack_o), exp_ack);
            chk("arb_err",    32'(err),   32'(m_err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string name, input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (dreq) begin
                ok = 1;
                break;
            end
            step();
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    // Ack every granted cycle until the grant ends; returns number of forwarded acks.
    task automatic run_burst(output int pulses);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            dack = dreq;
            @(negedge clk);
            if (ack_o != '0) pulses++;
            step();
            if (!dreq) break;
        end
        dack = 1'b0;
    endtask

    initial begin
        int pulses, lows, g2, exp_sel;

        // reset defaults
        rst = 0; req = '0; en = 4'hF; dack = 0;
        repeat (3) step();
        rst = 1;
        step(); step();
        @(negedge clk);
        chk("rst_dma_req", 32'(dreq), 0);
        chk("rst_dma_sel", 32'(dsel), 0);
        chk("rst_ack",     32'(ack_o), 0);
        chk("rst_err",     32'(err), 0);
        step();
        req = 4'b0101;
        step();
        @(negedge clk);
        chk("first_req", 32'(dreq), 1);
        chk("first_sel", 32'(dsel), 0);
        step();
        req = '0;
        repeat (3) step();

        // round-robin with all endpoints requesting
        rst = 0; step(); rst = 1;
        req = 4'hF;
        for (int g = 0; g < 5; g++) begin
            exp_sel = g % N;
            wait_grant("rr_grant_timeout", 20);
            chk("rr_order", 32'(dsel), exp_sel);
            dack = 1;
            @(negedge clk);
            chk("rr_ack_onehot", 32'(ack_o), 1 << exp_sel);
            step();
            dack = 0;
            req[dsel] = 1'b0;
            step();
            req = 4'hF;
        end
        req = '0;
        repeat (4) step();

        // burst limit, sole requester then competing requester
        req = 4'b0010;
        wait_grant("burst_grant_timeout", 10);
        chk("burst_sel", 32'(dsel), 1);
        run_burst(pulses);
        chk("burst_pulses", pulses, B);
        lows = 0;
        while (!dreq && lows < 10) begin
            lows++;
            step();
        end
        chk("burst_gap", lows, 2);
        chk("burst_regrant_sel", 32'(dsel), 1);
        req = 4'b0110;
        run_burst(pulses);
        chk("burst_pulses2", pulses, B);
        wait_grant("burst_next_timeout", 10);
        chk("burst_next_sel", 32'(dsel), 2);
        req = '0;
        repeat (4) step();

        // request drop coinciding with an ack
        req = 4'b1000;
        wait_grant("drop_grant_timeout", 10);
        chk("drop_sel", 32'(dsel), 3);
        dack = 1; req = '0;
        @(negedge clk);
        chk("drop_ack", 32'(ack_o), 32'h8);
        step();
        dack = 0;
        @(negedge clk);
        chk("drop_hold", 32'(dreq), 1);
        step();
        @(negedge clk);
        chk("drop_release", 32'(dreq), 0);
        step(); step();

        // enable cleared mid-grant, then masked endpoint never granted
        req = 4'b0100; en = 4'hF;
        wait_grant("en_grant_timeout", 10);
        chk("en_sel", 32'(dsel), 2);
        en = 4'b1011;
        step();
        @(negedge clk);
        chk("en_release", 32'(dreq), 0);
        g2 = 0;
        repeat (12) begin
            step();
            if (dreq) g2++;
        end
        chk("masked_never", g2, 0);

        // stray ack in IDLE
        req = '0; en = 4'hF;
        step(); step();
        dack = 1;
        @(negedge clk);
        chk("stray_ack", 32'(ack_o), 0);
        step();
        dack = 0;
        @(negedge clk);
        chk("stray_err", 32'(err), 1);
        step();
        @(negedge clk);
        chk("stray_err_clr", 32'(err), 0);
        step();

        // reset mid-grant with a concurrent ack
        req = 4'hF;
        wait_grant("rstg_grant_timeout", 10);
        dack = 1; rst = 0;
        @(negedge clk);
        chk("rstg_ack_blocked", 32'(ack_o), 0);
        step();
        rst = 1; dack = 0; req = 4'b0110;
        @(negedge clk);
        chk("rstg_req_low", 32'(dreq), 0);
        chk("rstg_sel_zero", 32'(dsel), 0);
        step();
        @(negedge clk);
        chk("rstg_post_req", 32'(dreq), 1);
        chk("rstg_post_sel", 32'(dsel), 1);
        step();

        // randomized traffic
        repeat (3000) begin
            req  = 4'($urandom);
            en   = (($urandom % 4) == 0) ? 4'($urandom) : 4'hF;
            dack = dreq ? (($urandom % 2) == 1) : (($urandom % 20) == 0);
            rst  = (($urandom % 200) != 0);
            step();
        end
        rst = 1; req = '0; dack = 0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule
